shake_xof_sequencer: RTL and testbench

//   Parametrised SHAKE request/response sequencer driving the 32-bit SHAKE stream interface.
//   - On start, sends the output-length header, the input-length header and N message words.
//   - Collects OUT_BITS of digest, byte-swapped per word, into res.
//   - Sits between the main controller and the SHAKE core.
//   - Message length (words) is a runtime input up to MAX_MSG_WORDS; digest length is a parameter.

---
 rtl/shake_xof_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_shake_xof_sequencer.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shake_xof_sequencer.sv
// shake_xof_sequencer
//   Sits between the main controller and a 32-bit SHAKE stream core.
//   For each request it sends the output-length header, the input-length
//   header and the message words. It then collects OUT_BITS of digest,
//   byte-swapped per word, into res.
//   Optional watchdog: define SHAKE_SEQ_TIMEOUT_EN to abort a request that
//   sees no handshake for TIMEOUT_CYCLES consecutive cycles.
//
//   state  | meaning
//   -------+-------------------------------------------------
//   IDLE   | waiting for start
//   OLEN   | presenting output-length header (OUT_BITS)
//   ILEN   | presenting input-length header (msg bits | 0x8000_0000)
//   MSG    | presenting message words, word 0 first
//   READ   | accepting digest words from the core
//   DONE   | one-cycle done pulse, busy drops on exit

module shake_xof_sequencer #(
    parameter int MAX_MSG_WORDS  = 4,
    parameter int OUT_BITS       = 128,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               start,
    input  logic [MAX_MSG_WORDS*32-1:0]        msg,
    input  logic [$clog2(MAX_MSG_WORDS+1)-1:0] msg_words,
    output logic                               busy,
    output logic                               done,
    output logic                               error,
    output logic [OUT_BITS-1:0]                res,
    output logic                               din_valid,
    output logic [31:0]                        din,
    input  logic                               din_ready,
    input  logic                               dout_valid,
    input  logic [31:0]                        dout,
    output logic                               dout_ready
);

    localparam int NW_W      = $clog2(MAX_MSG_WORDS + 1);
    localparam int OUT_WORDS = OUT_BITS / 32;
    localparam int RD_W      = $clog2(OUT_WORDS + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_OLEN, S_ILEN, S_MSG, S_READ, S_DONE
    } state_t;

    state_t                      state, state_n;
    logic [MAX_MSG_WORDS*32-1:0] msg_q, msg_n;
    logic [NW_W-1:0]             nwords_q, nwords_n;
    logic [NW_W-1:0]             left_q, left_n;
    logic [RD_W-1:0]             rd_q, rd_n;
    logic [31:0]                 din_n;
    logic                        din_valid_n, dout_ready_n;
    logic                        busy_n, done_n, error_n;
    logic [OUT_BITS-1:0]         res_n;
    logic                        in_xfer, out_xfer;
    logic [31:0]                 dout_swap;

    assign in_xfer   = din_valid & din_ready;
    assign out_xfer  = dout_valid & dout_ready;
    assign dout_swap = {dout[7:0], dout[15:8], dout[23:16], dout[31:24]};

`ifdef SHAKE_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_RELOAD = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_q, wd_n;

    // Watchdog down-counter; terminal count at zero means a stalled handshake.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) wd_q <= '0;
        else        wd_q <= wd_n;
    end
`endif

    // State, datapath and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            msg_q      <= '0;
            nwords_q   <= '0;
            left_q     <= '0;
            rd_q       <= '0;
            din        <= '0;
            din_valid  <= 1'b0;
            dout_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            res        <= '0;
        end else begin
            state      <= state_n;
            msg_q      <= msg_n;
            nwords_q   <= nwords_n;
            left_q     <= left_n;
            rd_q       <= rd_n;
            din        <= din_n;
            din_valid  <= din_valid_n;
            dout_ready <= dout_ready_n;
            busy       <= busy_n;
            done       <= done_n;
            error      <= error_n;
            res        <= res_n;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_n      = state;
        msg_n        = msg_q;
        nwords_n     = nwords_q;
        left_n       = left_q;
        rd_n         = rd_q;
        din_n        = din;
        din_valid_n  = din_valid;
        dout_ready_n = dout_ready;
        busy_n       = busy;
        done_n       = 1'b0;
        error_n      = 1'b0;
        res_n        = res;

        case (state)
            S_IDLE: begin
                if (start) begin
                    msg_n       = msg;
                    nwords_n    = (msg_words > NW_W'(MAX_MSG_WORDS)) ?
                                  NW_W'(MAX_MSG_WORDS) : msg_words;
                    res_n       = '0;
                    busy_n      = 1'b1;
                    din_n       = 32'(OUT_BITS);
                    din_valid_n = 1'b1;
                    state_n     = S_OLEN;
                end
            end
            S_OLEN: begin
                if (in_xfer) begin
                    din_n   = 32'h8000_0000 | (32'(nwords_q) << 5);
                    state_n = S_ILEN;
                end
            end
            S_ILEN: begin
                if (in_xfer) begin
                    if (nwords_q == '0) begin
                        din_valid_n  = 1'b0;
                        dout_ready_n = 1'b1;
                        rd_n         = RD_W'(OUT_WORDS - 1);
                        state_n      = S_READ;
                    end else begin
                        // Message is consumed from the low end by shifting.
                        din_n   = msg_q[31:0];
                        msg_n   = msg_q >> 32;
                        left_n  = nwords_q - NW_W'(1);
                        state_n = S_MSG;
                    end
                end
            end
            S_MSG: begin
                if (in_xfer) begin
                    if (left_q == '0) begin
                        din_valid_n  = 1'b0;
                        dout_ready_n = 1'b1;
                        rd_n         = RD_W'(OUT_WORDS - 1);
                        state_n      = S_READ;
                    end else begin
                        din_n  = msg_q[31:0];
                        msg_n  = msg_q >> 32;
                        left_n = left_q - NW_W'(1);
                    end
                end
            end
            S_READ: begin
                if (out_xfer) begin
                    res_n = (res << 32) | OUT_BITS'(dout_swap);
                    if (rd_q == '0) begin
                        dout_ready_n = 1'b0;
                        done_n       = 1'b1;
                        state_n      = S_DONE;
                    end else begin
                        rd_n = rd_q - RD_W'(1);
                    end
                end
            end
            S_DONE: begin
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

`ifdef SHAKE_SEQ_TIMEOUT_EN
        wd_n = WD_RELOAD;
        if (state == S_OLEN || state == S_ILEN || state == S_MSG || state == S_READ) begin
            if (in_xfer || out_xfer) begin
                wd_n = WD_RELOAD;
            end else if (wd_q == '0) begin
                error_n      = 1'b1;
                din_valid_n  = 1'b0;
                dout_ready_n = 1'b0;
                res_n        = '0;
                busy_n       = 1'b0;
                done_n       = 1'b0;
                state_n      = S_IDLE;
            end else begin
                wd_n = wd_q - WD_W'(1);
            end
        end
`endif
    end

endmodule

// File: tb/tb_shake_xof_sequencer.sv
// tb_shake_xof_sequencer
//   Self-checking bench. A behavioural SHAKE core mock drives din_ready and
//   presents queued digest words. Expected header/message streams and the
//   digest are computed from the request and the mock's digest words.
//   Define SHAKE_SEQ_TIMEOUT_EN to exercise the watchdog with a 16-cycle limit.

module tb_shake_xof_sequencer;

    localparam int MAXW = 4;
    localparam int OB   = 128;
    localparam int OW   = OB / 32;
    localparam int NWW  = $clog2(MAXW + 1);
`ifdef SHAKE_SEQ_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [MAXW*32-1:0] msg;
    logic [NWW-1:0]    msg_words;
    logic              busy, done, error;
    logic [OB-1:0]     res;
    logic              din_valid;
    logic [31:0]       din;
    logic              din_ready;
    logic              dout_valid;
    logic [31:0]       dout;
    logic              dout_ready;

    int checks = 0;
    int errors = 0;

    // Core mock state
    int          rdy_mode = 0;   // 0 always, 1 toggle, 2 held low, 3 random
    int          gap_len  = 0;   // -1 means random 0..3
    int          gap_cnt  = 0;
    logic [31:0] dq[$];
    int          dq_idx   = 0;
    logic [31:0] got[$];
    int          done_cnt = 0;
    int          err_cnt  = 0;
    int          hold_err = 0;
    logic        prev_pend = 1'b0;
    logic [31:0] prev_din  = '0;

    // Reference model results
    logic [31:0] exp_din[$];
    logic [OB-1:0] exp_res;

    shake_xof_sequencer #(
        .MAX_MSG_WORDS(MAXW),
        .OUT_BITS(OB),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .msg(msg),
        .msg_words(msg_words),
        .busy(busy),
        .done(done),
        .error(error),
        .res(res),
        .din_valid(din_valid),
        .din(din),
        .din_ready(din_ready),
        .dout_valid(dout_valid),
        .dout(dout),
        .dout_ready(dout_ready)
    );

    always #5 clock = ~clock;

    // Core mock: decides ready/valid on the falling edge, while DUT outputs are stable.
    always @(negedge clock) begin
        if (done)  done_cnt++;
        if (error) err_cnt++;
        if (!reset) prev_pend = 1'b0;
        else if (prev_pend && !error && (din_valid !== 1'b1 || din !== prev_din)) hold_err++;
        case (rdy_mode)
            0:       din_ready = 1'b1;
            1:       din_ready = ~din_ready;
            2:       din_ready = 1'b0;
            default: din_ready = 1'($urandom_range(0, 1));
        endcase
        if (reset && din_valid && din_ready) got.push_back(din);
        prev_pend = reset && din_valid && !din_ready;
        prev_din  = din;
        if (gap_cnt > 0) begin
            gap_cnt--;
            dout_valid = 1'b0;
        end else if (dq_idx < dq.size()) begin
            dout_valid = 1'b1;
            dout       = dq[dq_idx];
        end else begin
            dout_valid = 1'b0;
        end
        if (reset && dout_valid && dout_ready) begin
            dq_idx++;
            gap_cnt = (gap_len < 0) ? $urandom_range(0, 3) : gap_len;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic load_dout(input logic [31:0] w0, w1, w2, w3);
        dq = {w0, w1, w2, w3};
        dq_idx  = 0;
        gap_cnt = 0;
        got = {};
    endtask

    task automatic load_dout_rand();
        dq = {};
        for (int i = 0; i < OW; i++) dq.push_back($urandom);
        dq_idx  = 0;
        gap_cnt = 0;
        got = {};
    endtask

    // Expected stream and digest, built byte by byte from the request rules.
    task automatic model_req(input logic [MAXW*32-1:0] m, input int nreq);
        int n;
        n = (nreq > MAXW) ? MAXW : nreq;
        exp_din = {};
        exp_din.push_back(32'(OB));
        exp_din.push_back(32'h8000_0000 + 32'(n * 32));
        for (int k = 0; k < n; k++) exp_din.push_back(m[k*32 +: 32]);
        exp_res = '0;
        for (int i = 0; i < OW; i++)
            for (int b = 0; b < 4; b++)
                exp_res[OB-1-8*(4*i+b) -: 8] = dq[i][8*b +: 8];
    endtask

    task automatic kick(input logic [MAXW*32-1:0] m, input int nreq);
        @(negedge clock);
        msg       = m;
        msg_words = NWW'(nreq);
        start     = 1'b1;
        @(negedge clock);
        start     = 1'b0;
        #1;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            #1;
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; msg = '0; msg_words = '0;
        din_ready = 1'b0; dout_valid = 1'b0; dout = '0;
        repeat (2) @(negedge clock);
        #1;
        checks++;
        if ({busy, done, error, din_valid, dout_ready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 00000", {busy, done, error, din_valid, dout_ready});
        end
        checks++;
        if (res !== '0) begin errors++; $display("FAIL reset_res: got %h required 0", res); end
        checks++;
        if (din !== 32'h0) begin errors++; $display("FAIL reset_din: got %h required 0", din); end
        @(negedge clock);
        reset = 1'b1;
        #1;
    endtask

    task automatic test_directed();
        bit ok;
        int d0;
        logic [MAXW*32-1:0] m;
        m = {32'h0000_0000, 32'h1111_1111, 32'h8765_4321, 32'h1234_5678};
        rdy_mode = 0; gap_len = 0;
        load_dout(32'h0302_0100, 32'h0706_0504, 32'h0B0A_0908, 32'h0F0E_0D0C);
        model_req(m, 4);
        d0 = done_cnt;
        kick(m, 4);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL dir_busy: got %b required 1", busy); end
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL dir_done_timeout: got no done required done"); end
        checks++;
        if (res !== 128'h0001_0203_0405_0607_0809_0A0B_0C0D_0E0F) begin
            errors++;
            $display("FAIL dir_res: got %h required 000102030405060708090a0b0c0d0e0f", res);
        end
        checks++;
        if (got.size() != 6) begin
            errors++;
            $display("FAIL dir_din_count: got %0d required 6", got.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (got[i] !== exp_din[i]) begin
                    errors++;
                    $display("FAIL dir_din[%0d]: got %h required %h", i, got[i], exp_din[i]);
                end
            end
        end
        repeat (3) @(negedge clock);
        #1;
        checks++;
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL dir_done_pulses: got %0d required 1", done_cnt - d0); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL dir_busy_end: got %b required 0", busy); end
    endtask

    task automatic test_zero_words();
        bit ok;
        logic [MAXW*32-1:0] m;
        m = {$urandom, $urandom, $urandom, $urandom};
        rdy_mode = 0; gap_len = 1;
        load_dout_rand();
        model_req(m, 0);
        kick(m, 0);
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL zero_done_timeout: got no done required done"); end
        checks++;
        if (got.size() != 2 || got[0] !== 32'h0000_0080 || got[1] !== 32'h8000_0000) begin
            errors++;
            $display("FAIL zero_din: got %0d words required 2 words 00000080 80000000", got.size());
        end
        checks++;
        if (res !== exp_res) begin errors++; $display("FAIL zero_res: got %h required %h", res, exp_res); end
        checks++;
        if (dq_idx != OW) begin errors++; $display("FAIL zero_reads: got %0d required %0d", dq_idx, OW); end
    endtask

    task automatic test_stalls();
        bit ok;
        int h0;
        logic [MAXW*32-1:0] m;
        m = {32'h0000_0000, 32'h1111_1111, 32'h8765_4321, 32'h1234_5678};
        rdy_mode = 1; gap_len = 3;
        load_dout(32'h0302_0100, 32'h0706_0504, 32'h0B0A_0908, 32'h0F0E_0D0C);
        model_req(m, 4);
        h0 = hold_err;
        kick(m, 4);
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL stall_done_timeout: got no done required done"); end
        checks++;
        if (res !== 128'h0001_0203_0405_0607_0809_0A0B_0C0D_0E0F) begin
            errors++;
            $display("FAIL stall_res: got %h required 000102030405060708090a0b0c0d0e0f", res);
        end
        checks++;
        if (got != exp_din) begin errors++; $display("FAIL stall_din: got %0d words required %0d in order", got.size(), exp_din.size()); end
        checks++;
        if (hold_err != h0) begin errors++; $display("FAIL stall_hold: got %0d violations required 0", hold_err - h0); end
    endtask

    task automatic test_clamp();
        bit ok;
        logic [MAXW*32-1:0] m;
        m = {$urandom, $urandom, $urandom, $urandom};
        rdy_mode = 0; gap_len = 0;
        load_dout_rand();
        model_req(m, 7);
        kick(m, 7);
        wait_done(ok);
        checks++;
        if (got.size() < 2 || got[1] !== 32'h8000_0080) begin
            errors++;
            $display("FAIL clamp_header: got %0d words required header 80000080", got.size());
        end
        checks++;
        if (got != exp_din) begin errors++; $display("FAIL clamp_din: got %0d words required %0d", got.size(), exp_din.size()); end
        checks++;
        if (res !== exp_res) begin errors++; $display("FAIL clamp_res: got %h required %h", res, exp_res); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int d0;
        logic [MAXW*32-1:0] ma, mb;
        ma = {$urandom, $urandom, $urandom, $urandom};
        mb = {$urandom, $urandom, $urandom, $urandom};
        rdy_mode = 3; gap_len = 2;
        load_dout_rand();
        model_req(ma, 3);
        d0 = done_cnt;
        kick(ma, 3);
        repeat (2) @(negedge clock);
        msg = mb; msg_words = NWW'(1); start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done(ok);
        checks++;
        if (got != exp_din) begin errors++; $display("FAIL b2b_ignored_start: got %0d words required %0d", got.size(), exp_din.size()); end
        checks++;
        if (res !== exp_res) begin errors++; $display("FAIL b2b_res_a: got %h required %h", res, exp_res); end
        load_dout_rand();
        model_req(mb, 2);
        kick(mb, 2);
        checks++;
        if (busy !== 1'b1 || res !== '0) begin
            errors++;
            $display("FAIL b2b_accept: got busy %b res %h required busy 1 res 0", busy, res);
        end
        wait_done(ok);
        checks++;
        if (!ok || res !== exp_res) begin errors++; $display("FAIL b2b_res_b: got %h required %h", res, exp_res); end
        checks++;
        if (got != exp_din) begin errors++; $display("FAIL b2b_din_b: got %0d words required %0d", got.size(), exp_din.size()); end
        @(negedge clock);
        #1;
        checks++;
        if (done_cnt - d0 != 2) begin errors++; $display("FAIL b2b_done_pulses: got %0d required 2", done_cnt - d0); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int d0;
        logic [MAXW*32-1:0] m;
        m = {$urandom, $urandom, $urandom, $urandom};
        rdy_mode = 0; gap_len = 0;
        load_dout_rand();
        d0 = done_cnt;
        kick(m, 4);
        for (int i = 0; i < 20 && got.size() < 4; i++) begin
            @(negedge clock);
            #1;
        end
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, done, error, din_valid, dout_ready} !== 5'b0 || din !== 32'h0 || res !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got ctrl %b din %h required all 0", {busy, done, error, din_valid, dout_ready}, din);
        end
        @(negedge clock);
        reset = 1'b1;
        load_dout_rand();
        model_req(m, 2);
        kick(m, 2);
        wait_done(ok);
        checks++;
        if (got.size() == 0 || got[0] !== 32'h0000_0080) begin
            errors++;
            $display("FAIL rst_mid_restart: got %0d words required first 00000080", got.size());
        end
        checks++;
        if (got != exp_din || res !== exp_res) begin errors++; $display("FAIL rst_mid_result: got res %h required %h", res, exp_res); end
        @(negedge clock);
        #1;
        checks++;
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL rst_mid_done: got %0d required 1", done_cnt - d0); end
    endtask

    task automatic test_random();
        bit ok;
        int n, h0, d0;
        logic [MAXW*32-1:0] m;
        for (int it = 0; it < 10; it++) begin
            m = {$urandom, $urandom, $urandom, $urandom};
            n = $urandom_range(0, 7);
            rdy_mode = 3; gap_len = -1;
            load_dout_rand();
            model_req(m, n);
            h0 = hold_err;
            d0 = done_cnt;
            kick(m, n);
            wait_done(ok);
            checks++;
            if (!ok || res !== exp_res) begin errors++; $display("FAIL rand%0d_res: got %h required %h", it, res, exp_res); end
            checks++;
            if (got != exp_din) begin errors++; $display("FAIL rand%0d_din: got %0d words required %0d", it, got.size(), exp_din.size()); end
            @(negedge clock);
            #1;
            checks++;
            if (hold_err != h0 || done_cnt - d0 != 1) begin
                errors++;
                $display("FAIL rand%0d_proto: got hold %0d done %0d required 0 and 1", it, hold_err - h0, done_cnt - d0);
            end
        end
    endtask

`ifdef SHAKE_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int i, d0, e0;
        logic [MAXW*32-1:0] m;
        m = {$urandom, $urandom, $urandom, $urandom};
        rdy_mode = 2; gap_len = 0;
        load_dout_rand();
        d0 = done_cnt;
        e0 = err_cnt;
        kick(m, 2);
        for (i = 1; i <= 40; i++) begin
            @(negedge clock);
            #1;
            if (error === 1'b1) break;
        end
        checks++;
        if (i != TO) begin errors++; $display("FAIL timeout_cycles: got %0d required %0d", i, TO); end
        checks++;
        if (busy !== 1'b0 || din_valid !== 1'b0 || dout_ready !== 1'b0 || res !== '0) begin
            errors++;
            $display("FAIL timeout_state: got busy %b din_valid %b dout_ready %b required 0 0 0", busy, din_valid, dout_ready);
        end
        repeat (3) @(negedge clock);
        #1;
        checks++;
        if (done_cnt != d0 || err_cnt - e0 != 1) begin
            errors++;
            $display("FAIL timeout_pulses: got done %0d error %0d required 0 and 1", done_cnt - d0, err_cnt - e0);
        end
        rdy_mode = 0;
    endtask
`else
    task automatic test_no_timeout();
        logic [MAXW*32-1:0] m;
        m = {$urandom, $urandom, $urandom, $urandom};
        rdy_mode = 2; gap_len = 0;
        load_dout_rand();
        kick(m, 1);
        repeat (60) @(negedge clock);
        #1;
        checks++;
        if (busy !== 1'b1 || din_valid !== 1'b1 || din !== 32'h0000_0080) begin
            errors++;
            $display("FAIL stall_wait: got busy %b din_valid %b din %h required 1 1 00000080", busy, din_valid, din);
        end
        checks++;
        if (err_cnt != 0) begin errors++; $display("FAIL no_error: got %0d error pulses required 0", err_cnt); end
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        rdy_mode = 0;
        #1;
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_zero_words();
        test_stalls();
        test_clamp();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef SHAKE_SEQ_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
